// File: rtl/sdc_init_seq.sv
// sdc_init_seq: SD-card SPI-mode initialisation sequencer.
// Walks CMD0 -> CMD8 -> (CMD55/ACMD41 poll loop) -> CMD58 for v1 and v2 cards,
// drives an external command engine via one-pulse request/completion, and
// reports success (with SDHC/SDXC detection) or an error code.
// Optional build macro SDC_BLKLEN_EN: adds a CMD16 (512-byte block length)
// step for byte-addressed cards before completion.
module sdc_init_seq #(
    parameter int unsigned POLL_CNT   = 1350000,
    parameter int unsigned ACMD41_MAX = 1000,
    parameter int unsigned CMD0_MAX   = 8,
    parameter int unsigned CNT_W      = 22
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_cmd_we,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic [7:0]  o_crc,
    output logic        o_r3,
    input  logic        i_cmd_done,
    input  logic [7:0]  i_resp,
    input  logic [31:0] i_resp_ext,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_err_code,
    output logic        o_sdhc
);

    localparam int unsigned C0W = $clog2(CMD0_MAX + 1);
    localparam int unsigned AW  = $clog2(ACMD41_MAX + 1);

    typedef enum logic [3:0] {
        StIdle,
        StCmd0,
        StCmd8,
        StCmd55,
        StAcmd41,
        StPoll,
        StCmd58,
        StFin,
        StErr
`ifdef SDC_BLKLEN_EN
        , StCmd16
`endif
    } state_e;

    state_e           state_q, state_d;
    logic             issue;
    logic             cmd_we_q;
    logic [7:0]       cmd_q, cmd_d;
    logic [31:0]      arg_q, arg_d;
    logic [7:0]       crc_q, crc_d;
    logic             r3_q, r3_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             sdhc_q, sdhc_d;
    logic             hcs_q, hcs_d;
    logic [C0W-1:0]   cmd0_cnt_q, cmd0_cnt_d, cmd0_inc;
    logic [AW-1:0]    acmd_cnt_q, acmd_cnt_d, acmd_inc;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             resp_ok;

    // OCR bits between the CCS flag and the CMD8 echo pattern carry nothing we act on.
    logic unused_ext;
    assign unused_ext = ^i_resp_ext[29:12];

    // A completion in the same cycle as our own request cannot belong to it.
    assign resp_ok  = i_cmd_done && !cmd_we_q;
    assign cmd0_inc = cmd0_cnt_q + C0W'(1);
    assign acmd_inc = acmd_cnt_q + AW'(1);

    // Next-state logic: response decoding, retry/attempt counting and error selection.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        err_code_d = err_code_q;
        sdhc_d     = sdhc_q;
        hcs_d      = hcs_q;
        cmd0_cnt_d = cmd0_cnt_q;
        acmd_cnt_d = acmd_cnt_q;
        poll_cnt_d = poll_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StCmd0;
                    issue      = 1'b1;
                    err_code_d = 3'd0;
                    sdhc_d     = 1'b0;
                    hcs_d      = 1'b0;
                    cmd0_cnt_d = '0;
                    acmd_cnt_d = '0;
                    poll_cnt_d = '0;
                end
            end
            StCmd0: begin
                if (resp_ok) begin
                    if (i_resp == 8'h01) begin
                        state_d = StCmd8;
                        issue   = 1'b1;
                    end else begin
                        cmd0_cnt_d = cmd0_inc;
                        if (cmd0_inc == C0W'(CMD0_MAX)) begin
                            state_d    = StErr;
                            err_code_d = 3'd1;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
            end
            StCmd8: begin
                if (resp_ok) begin
                    if (i_resp == 8'h01 && i_resp_ext[11:0] == 12'h1AA) begin
                        hcs_d   = 1'b1;
                        state_d = StCmd55;
                        issue   = 1'b1;
                    end else if (i_resp[2]) begin
                        // Illegal-command response marks a v1 card.
                        hcs_d   = 1'b0;
                        state_d = StCmd55;
                        issue   = 1'b1;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 3'd2;
                    end
                end
            end
            StCmd55: begin
                if (resp_ok) begin
                    if (i_resp[7:1] == 7'd0) begin
                        state_d = StAcmd41;
                        issue   = 1'b1;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 3'd4;
                    end
                end
            end
            StAcmd41: begin
                if (resp_ok) begin
                    if (i_resp == 8'h00) begin
                        if (hcs_q) begin
                            state_d = StCmd58;
                            issue   = 1'b1;
                        end else begin
                            sdhc_d = 1'b0;
`ifdef SDC_BLKLEN_EN
                            state_d = StCmd16;
                            issue   = 1'b1;
`else
                            state_d = StFin;
`endif
                        end
                    end else if (i_resp == 8'h01) begin
                        acmd_cnt_d = acmd_inc;
                        if (acmd_inc == AW'(ACMD41_MAX)) begin
                            state_d    = StErr;
                            err_code_d = 3'd3;
                        end else begin
                            state_d = StPoll;
                        end
                    end else begin
                        state_d    = StErr;
                        err_code_d = 3'd4;
                    end
                end
            end
            StPoll: begin
                if (poll_cnt_q == CNT_W'(POLL_CNT - 1)) begin
                    poll_cnt_d = '0;
                    state_d    = StCmd55;
                    issue      = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end
            StCmd58: begin
                if (resp_ok) begin
                    if (i_resp != 8'h00) begin
                        state_d    = StErr;
                        err_code_d = 3'd4;
                    end else if (!i_resp_ext[31]) begin
                        // Power-up busy bit still clear: OCR is not yet valid.
                        state_d    = StErr;
                        err_code_d = 3'd5;
                    end else begin
                        sdhc_d = i_resp_ext[30];
`ifdef SDC_BLKLEN_EN
                        if (i_resp_ext[30]) begin
                            state_d = StFin;
                        end else begin
                            state_d = StCmd16;
                            issue   = 1'b1;
                        end
`else
                        state_d = StFin;
`endif
                    end
                end
            end
`ifdef SDC_BLKLEN_EN
            StCmd16: begin
                if (resp_ok) begin
                    if (i_resp == 8'h00) begin
                        state_d = StFin;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 3'd6;
                    end
                end
            end
`endif
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command fields for the state being entered; held between issues.
    always_comb begin
        cmd_d = cmd_q;
        arg_d = arg_q;
        crc_d = crc_q;
        r3_d  = r3_q;
        if (issue) begin
            case (state_d)
                StCmd0: begin
                    cmd_d = 8'h40; arg_d = 32'h0; crc_d = 8'h95; r3_d = 1'b0;
                end
                StCmd8: begin
                    cmd_d = 8'h48; arg_d = 32'h0000_01AA; crc_d = 8'h87; r3_d = 1'b1;
                end
                StCmd55: begin
                    cmd_d = 8'h77; arg_d = 32'h0; crc_d = 8'h65; r3_d = 1'b0;
                end
                StAcmd41: begin
                    cmd_d = 8'h69;
                    arg_d = {1'b0, hcs_q, 30'd0};
                    crc_d = hcs_q ? 8'h77 : 8'hE5;
                    r3_d  = 1'b0;
                end
                StCmd58: begin
                    cmd_d = 8'h7A; arg_d = 32'h0; crc_d = 8'hFD; r3_d = 1'b1;
                end
`ifdef SDC_BLKLEN_EN
                StCmd16: begin
                    cmd_d = 8'h50; arg_d = 32'h0000_0200; crc_d = 8'h15; r3_d = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cmd_we_q   <= 1'b0;
            cmd_q      <= 8'hFF;
            arg_q      <= 32'hFFFF_FFFF;
            crc_q      <= 8'hFF;
            r3_q       <= 1'b0;
            err_code_q <= 3'd0;
            sdhc_q     <= 1'b0;
            hcs_q      <= 1'b0;
            cmd0_cnt_q <= '0;
            acmd_cnt_q <= '0;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_we_q   <= issue;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            r3_q       <= r3_d;
            err_code_q <= err_code_d;
            sdhc_q     <= sdhc_d;
            hcs_q      <= hcs_d;
            cmd0_cnt_q <= cmd0_cnt_d;
            acmd_cnt_q <= acmd_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign o_cmd_we   = cmd_we_q;
    assign o_cmd      = cmd_q;
    assign o_arg      = arg_q;
    assign o_crc      = crc_q;
    assign o_r3       = r3_q;
    assign o_busy     = (state_q != StIdle) && (state_q != StFin) && (state_q != StErr);
    assign o_done     = (state_q == StFin);
    assign o_error    = (state_q == StErr);
    assign o_err_code = err_code_q;
    assign o_sdhc     = sdhc_q;

endmodule

// File: tb/tb_sdc_init_seq.sv
// Testbench for sdc_init_seq: scripted command engine, transaction-level model
// of the expected command stream and outcome, and a per-cycle compare process.
module tb_sdc_init_seq;

    localparam int unsigned POLL_CNT   = 10;
    localparam int unsigned ACMD41_MAX = 4;
    localparam int unsigned CMD0_MAX   = 8;
    localparam int unsigned CNT_W      = 4;
`ifdef SDC_BLKLEN_EN
    localparam int BLK = 1;
`else
    localparam int BLK = 0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        o_cmd_we;
    logic [7:0]  o_cmd;
    logic [31:0] o_arg;
    logic [7:0]  o_crc;
    logic        o_r3;
    logic        i_cmd_done;
    logic [7:0]  i_resp;
    logic [31:0] i_resp_ext;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [2:0]  o_err_code;
    logic        o_sdhc;

    sdc_init_seq #(
        .POLL_CNT  (POLL_CNT),
        .ACMD41_MAX(ACMD41_MAX),
        .CMD0_MAX  (CMD0_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .o_cmd_we  (o_cmd_we),
        .o_cmd     (o_cmd),
        .o_arg     (o_arg),
        .o_crc     (o_crc),
        .o_r3      (o_r3),
        .i_cmd_done(i_cmd_done),
        .i_resp    (i_resp),
        .i_resp_ext(i_resp_ext),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_err_code(o_err_code),
        .o_sdhc    (o_sdhc)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] arg;
        logic [7:0]  crc;
        logic        r3;
    } cmd_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scenario: what the scripted engine answers to each command.
    logic [7:0]  sc_cmd0, sc_r8, sc_r55, sc_a41f, sc_r58, sc_r16;
    logic [31:0] sc_e8, sc_e58;
    int          sc_a41n;  // number of leading "still idle" (0x01) ACMD41 answers

    // Model outputs.
    cmd_t        exp_src[$];
    bit          exp_ok;
    logic [2:0]  exp_code;
    bit          exp_sdhc;
    int          exp_polls;
    int          scen_gen = 0;

    // Observations owned by the compare process.
    int          cyc = 0;
    int          exp_idx = 0;
    bit          end_seen = 0;
    bit          poll_armed = 0;
    int          poll_t0 = 0;
    int          n_polls = 0;
    int          n_we = 0, n_cmd0 = 0, n_a41 = 0, n_cmd58 = 0, n_cmd16 = 0;
    int          seen_gen = 0;
    logic [7:0]  last_cmd = 8'hFF;
    cmd_t        cur;

    function automatic cmd_t mk(input logic [7:0] c, input bit hcs);
        cmd_t e;
        e.cmd = c;
        e.arg = 32'h0;
        e.r3  = 1'b0;
        e.crc = 8'hFF;
        case (c)
            8'h40: e.crc = 8'h95;
            8'h48: begin e.arg = 32'h0000_01AA; e.crc = 8'h87; e.r3 = 1'b1; end
            8'h77: e.crc = 8'h65;
            8'h69: begin
                e.arg = hcs ? 32'h4000_0000 : 32'h0;
                e.crc = hcs ? 8'h77 : 8'hE5;
            end
            8'h7A: begin e.crc = 8'hFD; e.r3 = 1'b1; end
            8'h50: begin e.arg = 32'h0000_0200; e.crc = 8'h15; end
            default: e.crc = 8'hFF;
        endcase
        return e;
    endfunction

    // Walk the init flow over the scripted answers: expected commands and result.
    task automatic build_expect();
        bit         hcs;
        int         att;
        logic [7:0] r;
        exp_src.delete();
        exp_ok = 0; exp_code = 3'd0; exp_sdhc = 0; exp_polls = 0; hcs = 0; att = 0;
        for (int i = 0; i < int'(CMD0_MAX); i++) begin
            exp_src.push_back(mk(8'h40, 0));
            if (sc_cmd0 == 8'h01) break;
        end
        if (sc_cmd0 != 8'h01) begin exp_code = 3'd1; return; end
        exp_src.push_back(mk(8'h48, 0));
        if (sc_r8 == 8'h01 && sc_e8[11:0] == 12'h1AA) hcs = 1;
        else if (sc_r8[2]) hcs = 0;
        else begin exp_code = 3'd2; return; end
        forever begin
            exp_src.push_back(mk(8'h77, hcs));
            if (sc_r55 > 8'h01) begin exp_code = 3'd4; return; end
            exp_src.push_back(mk(8'h69, hcs));
            r = (att < sc_a41n) ? 8'h01 : sc_a41f;
            if (r == 8'h00) break;
            if (r != 8'h01) begin exp_code = 3'd4; return; end
            att++;
            if (att == int'(ACMD41_MAX)) begin exp_code = 3'd3; return; end
            exp_polls++;
        end
        if (hcs) begin
            exp_src.push_back(mk(8'h7A, hcs));
            if (sc_r58 != 8'h00) begin exp_code = 3'd4; return; end
            if (!sc_e58[31]) begin exp_code = 3'd5; return; end
            exp_sdhc = sc_e58[30];
        end
        if (BLK == 1 && !exp_sdhc) begin
            exp_src.push_back(mk(8'h50, hcs));
            if (sc_r16 != 8'h00) begin exp_code = 3'd6; return; end
        end
        exp_ok = 1;
    endtask

    // Scripted command engine: answers each request a few cycles later.
    initial begin
        logic [7:0]  c;
        logic [7:0]  r;
        logic [31:0] x;
        int          eng_a41;
        eng_a41 = 0;
        i_cmd_done = 1'b0;
        i_resp = 8'hFF;
        i_resp_ext = 32'h0;
        forever begin
            @(negedge i_clk);
            while (o_cmd_we && !i_rst) begin
                c = o_cmd;
                x = 32'h0;
                case (c)
                    8'h40: begin r = sc_cmd0; eng_a41 = 0; end
                    8'h48: begin r = sc_r8; x = sc_e8; end
                    8'h77: r = sc_r55;
                    8'h69: begin r = (eng_a41 < sc_a41n) ? 8'h01 : sc_a41f; eng_a41++; end
                    8'h7A: begin r = sc_r58; x = sc_e58; end
                    8'h50: r = sc_r16;
                    default: r = 8'hFF;
                endcase
                repeat (2) @(negedge i_clk);
                i_cmd_done = 1'b1;
                i_resp = r;
                i_resp_ext = x;
                @(negedge i_clk);
                i_cmd_done = 1'b0;
            end
        end
    end

    // Compare process: checks every request and every end pulse against the model.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (scen_gen != seen_gen) begin
                seen_gen = scen_gen;
                exp_idx = 0; end_seen = 0; poll_armed = 0; n_polls = 0;
                n_cmd0 = 0; n_a41 = 0; n_cmd58 = 0; n_cmd16 = 0;
            end
            if (i_cmd_done && last_cmd == 8'h69 && i_resp == 8'h01) begin
                poll_armed = 1;
                poll_t0 = cyc;
            end
            if (o_cmd_we) begin
                n_we++;
                last_cmd = o_cmd;
                if (o_cmd == 8'h40) n_cmd0++;
                if (o_cmd == 8'h69) n_a41++;
                if (o_cmd == 8'h7A) n_cmd58++;
                if (o_cmd == 8'h50) n_cmd16++;
                if (exp_idx >= exp_src.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_cmd actual=%h required=none", o_cmd);
                end else begin
                    cur = exp_src[exp_idx];
                    exp_idx++;
                    chk("cmd_fields", {15'd0, o_cmd, o_arg, o_crc, o_r3}, {15'd0, cur});
                end
                chk("busy_code_clear", {60'd0, o_busy, o_err_code}, {60'd0, 1'b1, 3'd0});
                if (o_cmd == 8'h77 && poll_armed) begin
                    chk("poll_gap", 64'(cyc - poll_t0), 64'(POLL_CNT));
                    n_polls++;
                    poll_armed = 0;
                end
            end
            if (o_done || o_error) begin
                end_seen = 1;
                chk("end_pulse", {57'd0, o_done, o_error, o_busy, o_err_code, o_sdhc},
                    {57'd0, exp_ok, !exp_ok, 1'b0, exp_code, exp_sdhc});
            end
        end
    end

    task automatic set_scen(input logic [7:0] c0, input logic [7:0] r8, input logic [31:0] e8,
                            input logic [7:0] r55, input int a41n, input logic [7:0] a41f,
                            input logic [7:0] r58, input logic [31:0] e58,
                            input logic [7:0] r16);
        sc_cmd0 = c0; sc_r8 = r8; sc_e8 = e8; sc_r55 = r55; sc_a41n = a41n;
        sc_a41f = a41f; sc_r58 = r58; sc_e58 = e58; sc_r16 = r16;
    endtask

    // One full sequence from a start pulse; called on a falling edge.
    task automatic run(input string nm);
        build_expect();
        scen_gen++;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({nm, "_start"}, {59'd0, o_busy, o_err_code, o_sdhc}, {59'd0, 1'b1, 3'd0, 1'b0});
        repeat (4) @(negedge i_clk);
        i_start = 1'b1;  // must be ignored while busy
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (end_seen) break;
            @(negedge i_clk);
        end
        chk({nm, "_end_seen"}, 64'(end_seen), 64'd1);
        i_start = 1'b1;  // coincides with the end pulse: must be ignored
        @(negedge i_clk);
        i_start = 1'b0;
        chk({nm, "_start_at_pulse"}, {59'd0, o_busy, o_err_code, o_sdhc},
            {59'd0, 1'b0, exp_code, exp_sdhc});
        chk({nm, "_cmds_consumed"}, 64'(exp_idx), 64'(exp_src.size()));
        chk({nm, "_polls"}, 64'(n_polls), 64'(exp_polls));
        repeat (3) @(negedge i_clk);
    endtask

    logic [63:0] rst_exp;
    int          base_we;

    function automatic logic [63:0] out_vec();
        return {7'd0, o_cmd_we, o_cmd, o_arg, o_crc, o_r3, o_busy, o_done, o_error,
                o_err_code, o_sdhc};
    endfunction

    initial begin
        rst_exp = {7'd0, 1'b0, 8'hFF, 32'hFFFF_FFFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        i_rst = 1'b1;
        i_start = 1'b0;
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h01, 0, 8'h00, 8'h00, 32'hC0FF_8000, 8'h00);
        repeat (3) @(negedge i_clk);
        chk("reset_state", out_vec(), rst_exp);
        i_rst = 1'b0;
        @(negedge i_clk);

        // v2 SDHC card, two busy ACMD41 answers.
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h01, 2, 8'h00, 8'h00, 32'hC0FF_8000, 8'h00);
        run("v2_sdhc");
        chk("v2_sdhc_flag", 64'(o_sdhc), 64'd1);
        chk("v2_acmd41_count", 64'(n_a41), 64'd3);
        chk("v2_cmd58_count", 64'(n_cmd58), 64'd1);

        // v1 card.
        set_scen(8'h01, 8'h05, 32'h0, 8'h01, 0, 8'h00, 8'h00, 32'h0, 8'h00);
        run("v1");
        chk("v1_no_cmd58", 64'(n_cmd58), 64'd0);
        chk("v1_cmd16_count", 64'(n_cmd16), 64'(BLK));
        chk("v1_sdhc_flag", 64'(o_sdhc), 64'd0);

        // CMD0 never answers idle.
        set_scen(8'hFF, 8'h01, 32'h1AA, 8'h01, 0, 8'h00, 8'h00, 32'h0, 8'h00);
        run("cmd0_fail");
        chk("cmd0_count", 64'(n_cmd0), 64'd8);
        chk("cmd0_code", 64'(o_err_code), 64'd1);

        // ACMD41 stays idle forever.
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h01, 100, 8'h01, 8'h00, 32'h0, 8'h00);
        run("acmd41_tmo");
        chk("acmd41_count", 64'(n_a41), 64'd4);
        chk("acmd41_code", 64'(o_err_code), 64'd3);

        // OCR busy bit clear, then a fresh start must clear the code.
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h00, 0, 8'h00, 8'h00, 32'h40FF_8000, 8'h00);
        run("ocr_busy");
        chk("ocr_busy_code", 64'(o_err_code), 64'd5);
        set_scen(8'h01, 8'h05, 32'h0, 8'h00, 1, 8'h00, 8'h00, 32'h0, 8'h00);
        run("v1_after_err");

        // Bad CMD8 echo, bad CMD55 answer, bad ACMD41 answer.
        set_scen(8'h01, 8'h01, 32'h1AB, 8'h01, 0, 8'h00, 8'h00, 32'h0, 8'h00);
        run("cmd8_bad");
        chk("cmd8_code", 64'(o_err_code), 64'd2);
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h04, 0, 8'h00, 8'h00, 32'h0, 8'h00);
        run("cmd55_bad");
        chk("cmd55_code", 64'(o_err_code), 64'd4);
        set_scen(8'h01, 8'h05, 32'h0, 8'h01, 1, 8'h05, 8'h00, 32'h0, 8'h00);
        run("acmd41_bad");

        // v2 card with CCS clear (byte addressed).
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h01, 1, 8'h00, 8'h00, 32'h80FF_8000, 8'h00);
        run("v2_sdsc");
        chk("v2_sdsc_cmd16_count", 64'(n_cmd16), 64'(BLK));

        // Reset while polling aborts silently.
        set_scen(8'h01, 8'h01, 32'h1AA, 8'h01, 100, 8'h01, 8'h00, 32'h0, 8'h00);
        build_expect();
        scen_gen++;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (poll_armed) break;
            @(negedge i_clk);
        end
        chk("rst_reached_poll", 64'(poll_armed), 64'd1);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_mid_poll", out_vec(), rst_exp);
        base_we = n_we;
        repeat (3 * POLL_CNT) @(negedge i_clk);
        chk("rst_no_requests", 64'(n_we - base_we), 64'd0);
        chk("rst_no_pulse", 64'(end_seen), 64'd0);
        chk("rst_still_idle", out_vec(), rst_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdc_init_seq.md
Name: sdc_init_seq

Overview:
- Parametrised SD-card SPI-mode initialisation sequencer. Drives an external SD command engine through a one-pulse request / one-pulse completion handshake.
- Handles both v1 and v2 cards. Retries CMD0 and polls ACMD41 for a bounded number of attempts. Reads the OCR (CMD58) to detect SDHC/SDXC.
- Reports success or one of a set of error codes.
- Sits between the top-level controller and the command engine. Successor of the fixed v2-only init FSM.

Parameters:
- POLL_CNT, 1350000: idle cycles between ACMD41 attempts.
- ACMD41_MAX, 1000: maximum ACMD41 attempts before timeout.
- CMD0_MAX, 8: maximum CMD0 attempts before error.
- CNT_W, 22: width of the poll counter. Must satisfy 2^CNT_W > POLL_CNT.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset. Synchronous, active-high.
- i_start, in, 1: start-init pulse. Ignored while o_busy=1.
- o_cmd_we, out, 1: one-cycle command request to the engine.
- o_cmd, out, 8: command byte (0x40|index).
- o_arg, out, 32: command argument.
- o_crc, out, 8: CRC7 byte including the stop bit.
- o_r3, out, 1: request a 5-byte R3/R7 response. High for CMD8 and CMD58.
- i_cmd_done, in, 1: one-cycle completion from the engine.
- i_resp, in, 8: R1 byte. Valid with i_cmd_done.
- i_resp_ext, in, 32: trailing 4 bytes of R3/R7. Valid with i_cmd_done when o_r3 was set.
- o_busy, out, 1: sequence in progress.
- o_done, out, 1: one-cycle success pulse.
- o_error, out, 1: one-cycle failure pulse.
- o_err_code, out, 3: failure reason. Held until the next accepted i_start.
- o_sdhc, out, 1: card uses block addressing (CCS). Held until the next accepted i_start.

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, all counters 0, o_cmd_we=0, o_cmd=0xFF, o_arg=0xFFFFFFFF, o_crc=0xFF, o_r3=0, o_busy=0, o_done=0, o_error=0, o_err_code=0, o_sdhc=0.
- Reset mid-sequence aborts immediately. No done or error pulse is produced.
- Issue rule: entering a command state drives cmd/arg/crc/r3 and pulses o_cmd_we for exactly one cycle. The FSM then waits for i_cmd_done, with no timeout (the engine owns the bus timeout). cmd/arg/crc/r3 stay stable until the next issue.
- i_cmd_done is ignored outside wait states, and in the same cycle as o_cmd_we.
- States and transitions:
  - IDLE: on i_start, clear o_err_code and o_sdhc, clear counters, set o_busy=1, go to CMD0.
  - CMD0 (0x40, arg 0, crc 0x95): resp 0x01 goes to CMD8. Otherwise increment the CMD0 count; if it equals CMD0_MAX, error code 1; else reissue CMD0.
  - CMD8 (0x48, arg 0x000001AA, crc 0x87, r3=1):
    - resp 0x01 with i_resp_ext[11:0]=0x1AA: v2 card, HCS=1, go to CMD55.
    - resp bit2 set (illegal command, e.g. 0x05): v1 card, HCS=0, go to CMD55.
    - anything else: error code 2.
  - CMD55 (0x77, arg 0, crc 0x65): resp 0x00 or 0x01 goes to ACMD41. Else error code 4.
  - ACMD41 (0x69, arg HCS?0x40000000:0, crc 0x77 when HCS=1 / 0xE5 when HCS=0):
    - resp 0x00: v2 card goes to CMD58; v1 card goes to FIN with o_sdhc=0.
    - resp 0x01: increment the attempt count. If it equals ACMD41_MAX, error code 3. Else go to POLL.
    - other: error code 4.
  - POLL: count 0..POLL_CNT-1, then reset the counter and go to CMD55.
  - CMD58 (0x7A, arg 0, crc 0xFD, r3=1):
    - resp 0x00 and i_resp_ext[31]=1: o_sdhc<=i_resp_ext[30], go to FIN.
    - resp 0x00 and bit31=0: error code 5.
    - other resp: error code 4.
  - FIN: o_done=1 for one cycle, o_busy=0, go to IDLE.
  - ERR: o_error=1 for one cycle, o_busy=0, o_err_code latched, go to IDLE.
- o_done and o_error are never high together, and are never high while o_busy=1.
- An i_start arriving in the same cycle as the FIN/ERR pulse is ignored. Start is accepted from IDLE only.

Optional Feature:
- Macro SDC_BLKLEN_EN.
- When defined: after a successful init with o_sdhc=0 (v1 card, or v2 card with CCS=0), issue CMD16 (0x50, arg 0x00000200, crc 0x15) before FIN.
  - resp 0x00 goes to FIN.
  - other resp gives error code 6.
  - Cards with o_sdhc=1 skip CMD16.
- When undefined: no CMD16 state exists, and code 6 is never produced.

Test Plan:
- v2 SDHC card. Engine responses: CMD0→0x01, CMD8→0x01 ext 0x000001AA, CMD55→0x01, ACMD41→0x01 twice then 0x00, CMD58→0x00 ext 0xC0FF8000. Required: o_done pulse, o_sdhc=1, ACMD41 arg 0x40000000, two POLL intervals of POLL_CNT cycles each.
- v1 card. CMD8→0x05, ACMD41→0x00. Required: ACMD41 arg 0, no CMD58 issued, o_done, o_sdhc=0. With SDC_BLKLEN_EN: CMD16 arg 0x200 issued before o_done.
- CMD0 always returns 0xFF, CMD0_MAX=8. Required: exactly 8 CMD0 requests, then o_error with o_err_code=1.
- ACMD41 always returns 0x01, ACMD41_MAX=4, POLL_CNT=10. Required: 4 ACMD41 requests, then o_error with code 3.
- CMD58 ext 0x40FF8000 (busy bit clear). Required: o_error with code 5. Then i_start again clears o_err_code to 0.
- i_rst asserted while in POLL. Required: the next cycle shows IDLE with all outputs at reset values. i_start pulses while o_busy=1 cause no restart.
